log_calc_arbiter: RTL

LOG_CALC_ARBITER -- requirements
Module: log_calc_arbiter

---
 rtl/log_calc_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/log_calc_arbiter.sv
// Round-robin front end sharing one pipelined log unit among NUM_REQ requesters.
// A tag pipeline tracks which requester owns each in-flight result.

module log_calc_tag_stage #(
  parameter int ID_WIDTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                vld_d,
  input  logic [ID_WIDTH-1:0] id_d,
  output logic                vld_q,
  output logic [ID_WIDTH-1:0] id_q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      id_q  <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end
endmodule

module log_calc_arbiter #(
  parameter int BIT_WIDTH   = 32,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int LOG_LATENCY = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_x,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [BIT_WIDTH-1:0]         log_in_x,
  output logic                         log_enable,
  input  logic [BIT_WIDTH-1:0]         log_x,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [BIT_WIDTH-1:0]         rsp_log,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH:0]            in_flight
);
  localparam int L = LOG_LATENCY;

  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_x_a;
  logic [L-1:0]                      vld_pipe, vld_d;
  logic [L-1:0][ID_WIDTH-1:0]        id_pipe, id_d;
  logic [ID_WIDTH-1:0]               rr_ptr, rr_nxt, gnt_idx;
  logic                              gnt_vld;
  logic [BIT_WIDTH-1:0]              x_hold, gnt_x;
  int                                idx;

  assign req_x_a    = req_x;
  assign log_enable = !(rsp_valid && !rsp_ready);
  assign rsp_valid  = vld_pipe[L-1];
  assign rsp_id     = id_pipe[L-1];
  assign rsp_log    = log_x;

  // Walk the rotation backwards so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (log_enable && !reset) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = (int'(rr_ptr) + i) % NUM_REQ;
        if (req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx[ID_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    gnt_x     = req_x_a[gnt_idx];
    rr_nxt    = gnt_idx + 1'b1;
    if (int'(gnt_idx) == NUM_REQ - 1) rr_nxt = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // The unit's first stage samples every clock, so its input must hold across stalls.
  assign log_in_x = gnt_vld ? gnt_x : x_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      x_hold <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= rr_nxt;
      x_hold <= gnt_x;
    end
  end

  always_comb begin
    vld_d[0] = gnt_vld;
    id_d[0]  = gnt_idx;
    for (int k = 1; k < L; k++) begin
      vld_d[k] = vld_pipe[k-1];
      id_d[k]  = id_pipe[k-1];
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_tag
    log_calc_tag_stage #(.ID_WIDTH(ID_WIDTH)) u_stage (
      .clock (clock),
      .reset (reset),
      .en    (log_enable),
      .vld_d (vld_d[k]),
      .id_d  (id_d[k]),
      .vld_q (vld_pipe[k]),
      .id_q  (id_pipe[k])
    );
  end

  always_comb begin
    in_flight = '0;
    for (int k = 0; k < L; k++) in_flight = in_flight + (ID_WIDTH+1)'(vld_pipe[k]);
  end
endmodule
